// File: rtl/dmem_subword_pkg.sv
// Shared definitions for the sub-word data memory: access size and the
// helpers that decode the size and detect misaligned addresses.
package dmem_subword_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_e;

    // b wins over half when both are set.
    function automatic size_e decode_size(input logic b, input logic half);
        if (b) begin
            return SZ_BYTE;
        end else if (half) begin
            return SZ_HALF;
        end
        return SZ_WORD;
    endfunction

    function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/subword_ext.sv
// Selects the addressed byte/halfword lane of a 32-bit word and sign- or
// zero-extends it to 32 bits. Purely combinational.
module subword_ext
    import dmem_subword_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        zext,
    output logic [31:0] result
);

    logic [7:0]  lane8;
    logic [15:0] lane16;

    always_comb begin
        lane8  = word[{off, 3'b000} +: 8];
        lane16 = off[1] ? word[31:16] : word[15:0];
        result = word;
        if (size == SZ_BYTE) begin
            result = {{24{~zext & lane8[7]}}, lane8};
        end else if (size == SZ_HALF) begin
            result = {{16{~zext & lane16[15]}}, lane16};
        end
    end

endmodule

// File: rtl/dmem_subword.sv
// Word-organised data memory with byte/halfword/word stores and loads,
// registered load result, sticky misalignment flag and a store counter.
module dmem_subword
    import dmem_subword_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  memwrite,
    input  logic        memread,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    input  logic        half,
    input  logic        b,
    input  logic        bunsigned,
    output logic [31:0] readdata,
    output logic        rvalid,
    output logic        misalign,
    output logic [15:0] storecount
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];

    size_e         sz;
    logic [AW-1:0] idx;
    logic          store;
    logic          load;
    logic          bad;
    logic          do_write;
    logic [3:0]    wstrb;
    logic [31:0]   wdata;
    logic [31:0]   rword;
    logic [31:0]   ext_word;

    logic [31:0] readdata_q;
    logic        rvalid_q;
    logic        misalign_q;
    logic [15:0] storecount_q;

    // Address bits above the array size wrap silently.
    logic unused_adr;
    assign unused_adr = ^dataadr[31:AW+2];

    assign sz       = decode_size(b, half);
    assign idx      = dataadr[AW+1:2];
    assign store    = |memwrite;
    assign load     = memread & ~store;
    assign bad      = is_misaligned(sz, dataadr[1:0]);
    assign do_write = store & ~bad;
    assign rword    = mem[idx];

    // Store data is replicated across lanes so the strobe alone picks the target.
    always_comb begin
        wstrb = 4'b0000;
        wdata = writedata;
        case (sz)
            SZ_BYTE: begin
                wstrb = 4'b0001 << dataadr[1:0];
                wdata = {4{writedata[7:0]}};
            end
            SZ_HALF: begin
                wstrb = dataadr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{writedata[15:0]}};
            end
            default: wstrb = 4'b1111;
        endcase
    end

    // The array itself is not reset; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (reset && do_write) begin
            for (int k = 0; k < 4; k++) begin
                if (wstrb[k]) begin
                    mem[idx][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    subword_ext u_ext (
        .word   (rword),
        .off    (dataadr[1:0]),
        .size   (sz),
        .zext   (bunsigned),
        .result (ext_word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readdata_q   <= 32'h0;
            rvalid_q     <= 1'b0;
            misalign_q   <= 1'b0;
            storecount_q <= 16'h0;
        end else begin
            rvalid_q <= load;
            if (load) begin
                readdata_q <= bad ? 32'h0 : ext_word;
            end
            if ((store | load) & bad) begin
                misalign_q <= 1'b1;
            end
            if (do_write) begin
                storecount_q <= storecount_q + 16'd1;
            end
        end
    end

    assign readdata   = readdata_q;
    assign rvalid     = rvalid_q;
    assign misalign   = misalign_q;
    assign storecount = storecount_q;

endmodule

// File: tb/tb_dmem_subword.sv
// Self-checking bench for dmem_subword: byte-array reference model checked
// every cycle, directed literal checks, randomized traffic and counter wrap.
module tb_dmem_subword;

    localparam int unsigned DEPTH  = 64;
    localparam int unsigned NBYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  memwrite;
    logic        memread;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        half;
    logic        b;
    logic        bunsigned;
    logic [31:0] readdata;
    logic        rvalid;
    logic        misalign;
    logic [15:0] storecount;

    always #5 clk = ~clk;

    dmem_subword #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .memwrite   (memwrite),
        .memread    (memread),
        .dataadr    (dataadr),
        .writedata  (writedata),
        .half       (half),
        .b          (b),
        .bunsigned  (bunsigned),
        .readdata   (readdata),
        .rvalid     (rvalid),
        .misalign   (misalign),
        .storecount (storecount)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  m_mem [NBYTES];
    logic [31:0] exp_rdata;
    logic        exp_rvalid;
    logic        exp_mis;
    logic [15:0] exp_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        exp_rdata  = 32'h0;
        exp_rvalid = 1'b0;
        exp_mis    = 1'b0;
        exp_cnt    = 16'h0;
    endfunction

    // Memory as a flat little-endian byte array; size in bytes drives everything.
    function automatic void model_step(input logic [1:0] mw, input logic mr,
                                       input logic [31:0] adr, input logic [31:0] wd,
                                       input logic hb, input logic bb, input logic uns);
        int unsigned sz;
        int unsigned a;
        logic [31:0] v;
        sz = bb ? 1 : (hb ? 2 : 4);
        a  = adr % NBYTES;
        if (mw != 2'b00) begin
            exp_rvalid = 1'b0;
            if (a % sz != 0) begin
                exp_mis = 1'b1;
            end else begin
                for (int i = 0; i < int'(sz); i++) m_mem[a+i] = wd[8*i +: 8];
                exp_cnt = exp_cnt + 16'd1;
            end
        end else if (mr) begin
            exp_rvalid = 1'b1;
            if (a % sz != 0) begin
                exp_mis   = 1'b1;
                exp_rdata = 32'h0;
            end else begin
                v = 32'h0;
                for (int i = 0; i < int'(sz); i++) v = v | (32'(m_mem[a+i]) << (8*i));
                if (!uns && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
                exp_rdata = v;
            end
        end else begin
            exp_rvalid = 1'b0;
        end
    endfunction

    task automatic compare();
        chk("readdata", readdata, exp_rdata);
        chk("rvalid", 32'(rvalid), 32'(exp_rvalid));
        chk("misalign", 32'(misalign), 32'(exp_mis));
        chk("storecount", 32'(storecount), 32'(exp_cnt));
    endtask

    // Called and returns at posedge+1.
    task automatic cycle(input logic [1:0] mw, input logic mr, input logic [31:0] adr,
                         input logic [31:0] wd, input logic hb, input logic bb,
                         input logic uns);
        memwrite  = mw;
        memread   = mr;
        dataadr   = adr;
        writedata = wd;
        half      = hb;
        b         = bb;
        bunsigned = uns;
        @(posedge clk);
        if (reset) model_step(mw, mr, adr, wd, hb, bb, uns);
        #1;
        compare();
    endtask

    task automatic idle();
        cycle(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b0;
        model_reset();
        #1 compare();
        #2 reset = 1'b1;
    endtask

    initial begin
        int unsigned r;
        int unsigned sel;
        logic [31:0] adr;
        logic        hb;
        logic        bb;

        reset = 1'b0;
        memwrite = 2'b00; memread = 1'b0; dataadr = 32'h0; writedata = 32'h0;
        half = 1'b0; b = 1'b0; bunsigned = 1'b0;
        for (int i = 0; i < int'(NBYTES); i++) m_mem[i] = 8'h0;
        model_reset();

        @(posedge clk);
        #1;
        compare();
        chk("rst_storecount", 32'(storecount), 32'h0);
        #2 reset = 1'b1;

        for (int w = 0; w < int'(DEPTH); w++) cycle(2'b11, 1'b0, 32'(w * 4), $urandom, 1'b0, 1'b0, 1'b0);
        pulse_reset();
        chk("rst_cnt_after_fill", 32'(storecount), 32'h0);

        // Directed sequence with hand-computed results.
        cycle(2'b11, 1'b0, 32'h80, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        cycle(2'b10, 1'b0, 32'h80, 32'h0000_FFFF, 1'b1, 1'b0, 1'b0);
        cycle(2'b00, 1'b1, 32'h80, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("lw80_a", readdata, 32'h0000_FFFF);
        chk("lw80_a_rvalid", 32'(rvalid), 32'h1);
        chk("cnt2", 32'(storecount), 32'h2);
        idle();
        chk("rvalid_drop", 32'(rvalid), 32'h0);
        chk("rdata_hold", readdata, 32'h0000_FFFF);

        cycle(2'b10, 1'b0, 32'h82, 32'h0000_ABCD, 1'b1, 1'b0, 1'b0);
        cycle(2'b00, 1'b1, 32'h80, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("lw80_b", readdata, 32'hABCD_FFFF);
        cycle(2'b00, 1'b1, 32'h82, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("lh82", readdata, 32'hFFFF_ABCD);
        cycle(2'b00, 1'b1, 32'h82, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("lhu82", readdata, 32'h0000_ABCD);

        cycle(2'b01, 1'b0, 32'h81, 32'h0000_0080, 1'b0, 1'b1, 1'b0);
        cycle(2'b00, 1'b1, 32'h81, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("lb81", readdata, 32'hFFFF_FF80);
        cycle(2'b00, 1'b1, 32'h81, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("lbu81", readdata, 32'h0000_0080);
        cycle(2'b00, 1'b1, 32'h80, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("lw80_c", readdata, 32'hABCD_80FF);

        cycle(2'b10, 1'b0, 32'h81, 32'h0000_1234, 1'b1, 1'b0, 1'b0);
        chk("mis_set", 32'(misalign), 32'h1);
        cycle(2'b11, 1'b0, 32'h82, 32'h5555_5555, 1'b0, 1'b0, 1'b0);
        chk("cnt_after_mis", 32'(storecount), 32'h4);
        cycle(2'b00, 1'b1, 32'h80, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("lw80_unchanged", readdata, 32'hABCD_80FF);
        cycle(2'b00, 1'b1, 32'h81, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("lh81_rvalid", 32'(rvalid), 32'h1);
        chk("lh81_zero", readdata, 32'h0);
        idle();
        chk("mis_held", 32'(misalign), 32'h1);

        // Load in flight when reset hits mid-cycle.
        cycle(2'b00, 1'b1, 32'h80, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_rvalid", 32'(rvalid), 32'h1);
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("async_rvalid", 32'(rvalid), 32'h0);
        chk("async_rdata", readdata, 32'h0);
        chk("async_mis", 32'(misalign), 32'h0);
        chk("async_cnt", 32'(storecount), 32'h0);
        #2 reset = 1'b1;
        for (int i = 0; i < 3; i++) idle();
        chk("no_rvalid_after_rst", 32'(rvalid), 32'h0);

        // Store and load together: store wins.
        cycle(2'b01, 1'b1, 32'h84, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);
        chk("st_ld_rvalid", 32'(rvalid), 32'h0);
        chk("st_ld_cnt", 32'(storecount), 32'h1);
        cycle(2'b00, 1'b1, 32'h84, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("lw84", readdata, 32'hCAFE_F00D);

        // Randomized traffic, with occasional reset held across a store edge.
        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 2);
            bb  = (sel == 0);
            hb  = (sel == 1) ? 1'b1 : ((sel == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
            adr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sel == 1) adr[0] = 1'b0;
                if (sel == 2) adr[1:0] = 2'b00;
            end
            r = $urandom_range(0, 99);
            if (r < 2) begin
                reset = 1'b0;
                model_reset();
                cycle(2'($urandom_range(1, 3)), 1'b0, adr, $urandom, hb, bb, 1'b0);
                #3 reset = 1'b1;
            end else if (r < 42) begin
                cycle(2'($urandom_range(1, 3)), 1'b0, adr, $urandom, hb, bb, 1'b0);
            end else if (r < 82) begin
                cycle(2'b00, 1'b1, adr, $urandom, hb, bb, 1'($urandom_range(0, 1)));
            end else if (r < 92) begin
                cycle(2'($urandom_range(1, 3)), 1'b1, adr, $urandom, hb, bb, 1'b0);
            end else begin
                idle();
            end
        end

        // Store counter wrap.
        pulse_reset();
        for (int i = 0; i < 65535; i++) cycle(2'b11, 1'b0, $urandom & 32'hFFFF_FFFC, $urandom, 1'b0, 1'b0, 1'b0);
        chk("cnt_ffff", 32'(storecount), 32'h0000_FFFF);
        cycle(2'b11, 1'b0, 32'h0, 32'h1, 1'b0, 1'b0, 1'b0);
        chk("cnt_wrap", 32'(storecount), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
